// File: rtl/lsu_sram_bridge_if.sv
// Request/response and data-SRAM signal bundle for the LSU bridge.
// The bridge uses the slave view; the core and the SRAM use master and sram.
interface lsu_sram_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_dest;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [4:0]        resp_dest;
  logic              resp_ale;
  logic              data_sram_en;
  logic [3:0]        data_sram_we;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [31:0]       data_sram_wdata;
  logic [31:0]       data_sram_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_dest,
    input  flush, resp_ready, data_sram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_dest, resp_ale,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_dest,
    output flush, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_dest, resp_ale
  );

  modport sram (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/lsu_sram_bridge.sv
// Load/store unit bridge: valid/ready requests to a fixed-latency data SRAM,
// with byte strobes, load lane select and extension, and alignment errors.
module lsu_sram_bridge #(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  lsu_sram_bridge_if.slave bus
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              rdy_q, rdy_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              en_q, en_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [4:0]        dest_q, dest_d;
  logic              ale_q, ale_d;

  logic        accept;
  logic        mis;
  logic [1:0]  sz;
  logic [1:0]  a_lo;
  logic [3:0]  strb;
  logic [31:0] rep;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;
  logic [31:0] ld_v;

  assign accept = bus.req_valid & rdy_q;
  assign sz     = bus.req_op[1:0];
  assign a_lo   = bus.req_addr[1:0];

  // Request decode: alignment error, write strobes, lane replication.
  always_comb begin
    mis  = 1'b0;
    strb = 4'b1111;
    rep  = bus.req_wdata;
    unique case (sz)
      2'b00: begin
        strb = 4'b0001 << a_lo;
        rep  = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        mis  = a_lo[0];
        strb = 4'b0011 << {a_lo[1], 1'b0};
        rep  = {2{bus.req_wdata[15:0]}};
      end
      2'b10: mis = |a_lo;
      default: mis = 1'b1;
    endcase
  end

  // Load lane select and sign/zero extension of the SRAM word.
  always_comb begin
    byte_v = off_q[0] ? bus.data_sram_rdata[15:8]
                      : bus.data_sram_rdata[7:0];
    if (off_q[1])
      byte_v = off_q[0] ? bus.data_sram_rdata[31:24]
                        : bus.data_sram_rdata[23:16];
    half_v = off_q[1] ? bus.data_sram_rdata[31:16]
                      : bus.data_sram_rdata[15:0];
    sgn    = ~op_q[2];
    ld_v   = bus.data_sram_rdata;
    unique case (op_q[1:0])
      2'b00:   ld_v = {{24{sgn & byte_v[7]}}, byte_v};
      2'b01:   ld_v = {{16{sgn & half_v[15]}}, half_v};
      default: ld_v = bus.data_sram_rdata;
    endcase
  end

  // Next-state and registered-output logic for the four-state sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    op_d    = op_q;
    off_d   = off_q;
    en_d    = 1'b0;
    we_d    = 4'b0000;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dest_d  = dest_q;
    ale_d   = ale_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (accept) begin
          op_d    = bus.req_op;
          off_d   = a_lo;
          dest_d  = bus.req_dest;
          rdata_d = 32'h0;
          ale_d   = mis;
          if (mis) begin
            state_d = RESP;
          end else begin
            state_d = ISSUE;
            en_d    = 1'b1;
            we_d    = bus.req_op[3] ? strb : 4'b0000;
            addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            wdata_d = rep;
          end
        end
      end
      ISSUE: begin
        if (bus.flush) drop_d = 1'b1;
        if (op_q[3]) begin
          state_d = (drop_q | bus.flush) ? IDLE : RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LATENCY);
        end
      end
      WAIT: begin
        if (bus.flush) drop_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          cnt_d = '0;
          if (drop_q | bus.flush) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            rdata_d = ld_v;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.flush | bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy_d = (state_d == IDLE);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      rdy_q   <= 1'b0;
      op_q    <= 4'h0;
      off_q   <= 2'b00;
      en_q    <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      dest_q  <= 5'h0;
      ale_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      rdy_q   <= rdy_d;
      op_q    <= op_d;
      off_q   <= off_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dest_q  <= dest_d;
      ale_q   <= ale_d;
    end
  end

  assign bus.req_ready       = rdy_q;
  assign bus.resp_valid      = (state_q == RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_dest       = dest_q;
  assign bus.resp_ale        = ale_q;
  assign bus.data_sram_en    = en_q;
  assign bus.data_sram_we    = we_q;
  assign bus.data_sram_addr  = addr_q;
  assign bus.data_sram_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Randomized bench for lsu_sram_bridge against a byte-level memory model.
// A latency-accurate SRAM model drives read data only in its valid cycle.
module tb_lsu_sram_bridge;

  localparam int LAT = 4;

  logic clk;
  logic reset;

  lsu_sram_bridge_if #(.ADDR_W(32)) bus ();

  lsu_sram_bridge #(
    .ADDR_W(32),
    .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sram [64];
  logic [31:0] refm [64];
  logic [31:0] pipe_d [LAT];
  logic        pipe_v [LAT];

  // SRAM: strobed writes, reads valid exactly LAT cycles after enable
  always @(posedge clk) begin
    if (bus.data_sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_sram_we[b])
          sram[bus.data_sram_addr[7:2]][8*b +: 8] <=
            bus.data_sram_wdata[8*b +: 8];
    end
    pipe_v[0] <= bus.data_sram_en && (bus.data_sram_we == 4'h0);
    pipe_d[0] <= sram[bus.data_sram_addr[7:2]];
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign bus.data_sram_rdata =
    pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] w,
                                           input logic [3:0] op,
                                           input logic [31:0] a);
    logic [31:0] v;
    case (op[1:0])
      2'd0: begin
        v = (w >> (8 * a[1:0])) & 32'hFF;
        if (!op[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (w >> (16 * a[1])) & 32'hFFFF;
        if (!op[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_rdy"},  32'(bus.req_ready), 0);
    check_eq({tag, "_rv"},   32'(bus.resp_valid), 0);
    check_eq({tag, "_rd"},   bus.resp_rdata, 0);
    check_eq({tag, "_dst"},  32'(bus.resp_dest), 0);
    check_eq({tag, "_ale"},  32'(bus.resp_ale), 0);
    check_eq({tag, "_en"},   32'(bus.data_sram_en), 0);
    check_eq({tag, "_we"},   32'(bus.data_sram_we), 0);
    check_eq({tag, "_addr"}, bus.data_sram_addr, 0);
    check_eq({tag, "_wd"},   bus.data_sram_wdata, 0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!bus.req_ready && w < 20) begin
      step();
      w++;
    end
    check_eq("ready_wait", 32'(bus.req_ready), 1);
  endtask

  // fmode: 0 none, 1 flush in flight, 2 flush in RESP, 3 flush at accept
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] dest,
                         input int stall, input int fmode);
    int sz, nb, lat, fk, idx, off;
    bit st, ale, dropped;
    logic [31:0] erd, rep, mask;
    sz  = int'(op[1:0]);
    st  = op[3];
    off = int'(addr[1:0]);
    idx = int'(addr[7:2]);
    ale = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
    nb  = 1 << sz;
    lat = ale ? 1 : (st ? 2 : 2 + LAT);
    fk  = -1;
    if (fmode == 1 && lat > 1) fk = $urandom_range(1, lat - 1);
    if (fmode == 2) fk = lat;
    if (fmode == 3) fk = 0;
    dropped = (fk >= 1 && fk < lat);
    mask = ((32'd1 << nb) - 1) << off;
    rep  = (sz == 0) ? (wdata & 32'hFF) * 32'h0101_0101 :
           (sz == 1) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    erd = 32'h0;
    if (!ale && !st) erd = exp_load(refm[idx], op, addr);
    if (!ale && st)
      for (int i = 0; i < nb; i++)
        refm[idx][8*(off+i) +: 8] = wdata[8*i +: 8];

    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_dest  = dest;
    bus.flush     = (fk == 0);
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;

    for (int k = 1; k <= lat; k++) begin
      check_eq("en", 32'(bus.data_sram_en), 32'(k == 1 && !ale));
      if (k == 1 && !ale) begin
        check_eq("we", 32'(bus.data_sram_we), st ? mask : 0);
        check_eq("saddr", bus.data_sram_addr, addr & 32'hFFFF_FFFC);
        if (st) check_eq("swdata", bus.data_sram_wdata, rep);
      end
      check_eq("rvalid", 32'(bus.resp_valid), 32'(k == lat && !dropped));
      check_eq("rdy_busy", 32'(bus.req_ready), 32'(k == lat && dropped));
      if (k < lat) begin
        bus.flush = (k == fk);
        step();
      end
    end
    bus.flush = 1'b0;
    if (dropped) return;

    for (int s = 0; s <= stall; s++) begin
      check_eq("rvalid_hold", 32'(bus.resp_valid), 1);
      check_eq("rdata", bus.resp_rdata, erd);
      check_eq("rdest", 32'(bus.resp_dest), 32'(dest));
      check_eq("rale", 32'(bus.resp_ale), 32'(ale));
      check_eq("rdy_resp", 32'(bus.req_ready), 0);
      check_eq("en_resp", 32'(bus.data_sram_en), 0);
      if (s == stall) begin
        if (fk == lat) bus.flush = 1'b1;
        else bus.resp_ready = 1'b1;
      end
      step();
    end
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    check_eq("rvalid_done", 32'(bus.resp_valid), 0);
    check_eq("rdy_done", 32'(bus.req_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    int sz, fm;
    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      sram[i] = r;
      refm[i] = r;
    end
    for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = 4'h0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_dest   = 5'h0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;
    step();
    step();
    check_reset_outs("rst");
    reset = 1'b0;
    step();
    check_eq("rdy_after_rst", 32'(bus.req_ready), 1);

    // st.b lane 3, replicated data
    run_txn(4'b1000, 32'h1C00_0013, 32'h0000_00A5, 5'd1, 0, 0);
    sram[0] = 32'h8001_7FFF;
    refm[0] = 32'h8001_7FFF;
    run_txn(4'b0001, 32'h0000_0102, 32'h0, 5'd2, 0, 0);
    run_txn(4'b0101, 32'h0000_0102, 32'h0, 5'd3, 0, 0);
    // ALE cases
    run_txn(4'b0010, 32'h0000_0101, 32'h0, 5'd4, 0, 0);
    run_txn(4'b0011, 32'h0000_0100, 32'h0, 5'd6, 0, 0);
    // ld.b sign with backpressure
    sram[1] = 32'h8012_3456;
    refm[1] = 32'h8012_3456;
    run_txn(4'b0000, 32'h0000_0007, 32'h0, 5'd5, 3, 0);
    // flush during WAIT of ld.w, then st.w
    run_txn(4'b0010, 32'h0000_0020, 32'h0, 5'd7, 0, 1);
    run_txn(4'b1010, 32'h0000_0024, 32'h1234_5678, 5'd8, 0, 0);
    run_txn(4'b0010, 32'h0000_0024, 32'h0, 5'd9, 0, 0);

    // reset in WAIT
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = 4'b0010;
    bus.req_addr  = 32'h0000_0040;
    bus.req_dest  = 5'd10;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check_reset_outs("rst_wait");
    reset = 1'b0;
    step();
    check_eq("rdy_post_rst", 32'(bus.req_ready), 1);
    check_eq("rv_post_rst", 32'(bus.resp_valid), 0);
    run_txn(4'b0010, 32'h0000_0040, 32'h0, 5'd11, 0, 0);

    for (int t = 0; t < 150; t++) begin
      sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      op = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'(sz)};
      r  = $urandom;
      fm = $urandom_range(0, 9);
      if (fm > 3) fm = 0;
      run_txn(op, {r[31:8], 6'($urandom_range(0, 63)),
                   2'($urandom_range(0, 3))},
              $urandom, 5'($urandom_range(0, 31)),
              $urandom_range(0, 3), fm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
